// File: rtl/subleq_run_ctrl.sv
// rtl/subleq_run_ctrl.sv - run controller for the 8-bit subleq core: core reset, memory arbitration, stop detection
// Host owns the shared memory outside RUN; during RUN the core bus is snooped for halt, budget and abort.
module subleq_run_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_max_instr,
  input  logic             i_host_req,
  input  logic             i_host_we,
  input  logic [7:0]       i_host_addr,
  input  logic [7:0]       i_host_wdata,
  output logic             o_host_ack,
  output logic [7:0]       o_host_rdata,
  output logic             o_core_rstn,
  input  logic [7:0]       i_core_raddr,
  input  logic [7:0]       i_core_waddr,
  input  logic [7:0]       i_core_wdata,
  input  logic             i_core_we,
  output logic [7:0]       o_mem_raddr,
  output logic [7:0]       o_mem_waddr,
  output logic [7:0]       o_mem_wdata,
  output logic             o_mem_we,
  input  logic [7:0]       i_mem_rdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_halt,
  output logic             o_timeout,
  output logic             o_aborted,
  output logic [CNT_W-1:0] o_instr_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               core_rstn_q, core_rstn_d;
  logic               host_ack_q, host_ack_d;
  logic [7:0]         host_rdata_q, host_rdata_d;
  logic               rd_pend_q, rd_pend_d;
  logic               wr_q, wr_d;
  logic               start_pend_q, start_pend_d;
  logic               halt_q, halt_d;
  logic               timeout_q, timeout_d;
  logic               aborted_q, aborted_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   budget_q, budget_d;
  logic [3:0]         phase_q, phase_d;
  logic [7:0]         base_q, base_d;
  logic [7:0]         target_q, target_d;
  logic               taken_q, taken_d;
  logic               abort_seen_q, abort_seen_d;

  logic new_req;
  logic start_req;
  logic abort_now;
  logic core_owns;

  // The ack cycle itself never re-accepts: the host is still holding req while it sees the ack.
  assign new_req   = i_host_req && !host_ack_q && !rd_pend_q;
  assign start_req = i_start || start_pend_q;
  assign abort_now = abort_seen_q || i_abort;
  assign core_owns = (state_q == S_RUN);

  always_comb begin
    state_d      = state_q;
    core_rstn_d  = core_rstn_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    rd_pend_d    = rd_pend_q;
    wr_d         = 1'b0;
    start_pend_d = start_pend_q;
    halt_d       = halt_q;
    timeout_d    = timeout_q;
    aborted_d    = aborted_q;
    count_d      = count_q;
    budget_d     = budget_q;
    phase_d      = phase_q;
    base_d       = base_q;
    target_d     = target_q;
    taken_d      = taken_q;
    abort_seen_d = abort_seen_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (rd_pend_q) begin
          host_rdata_d = i_mem_rdata;
          host_ack_d   = 1'b1;
          rd_pend_d    = 1'b0;
        end else if (new_req) begin
          if (i_host_we) begin
            wr_d       = 1'b1;
            host_ack_d = 1'b1;
          end else begin
            rd_pend_d  = 1'b1;
          end
        end

        if (start_req) begin
          if (new_req || rd_pend_q) begin
            start_pend_d = 1'b1;
          end else begin
            start_pend_d = 1'b0;
            halt_d       = 1'b0;
            timeout_d    = 1'b0;
            aborted_d    = 1'b0;
            count_d      = '0;
            budget_d     = i_max_instr;
            phase_d      = 4'd0;
            abort_seen_d = 1'b0;
            core_rstn_d  = 1'b1;
            state_d      = S_RUN;
          end
        end
      end

      S_RUN: begin
        abort_seen_d = abort_now;
        phase_d      = (phase_q == 4'd11) ? 4'd0 : phase_q + 4'd1;
        case (phase_q)
          4'd0:  base_d   = i_core_raddr;
          4'd8:  taken_d  = ~i_core_wdata[7];
          4'd10: target_d = i_mem_rdata;
          4'd11: begin
            count_d      = count_q + CNT_W'(1);
            abort_seen_d = 1'b0;
            if (taken_q && (target_q == base_q)) begin
              halt_d      = 1'b1;
              state_d     = S_STOP;
              core_rstn_d = 1'b0;
            end else if ((budget_q != '0) && (count_d == budget_q)) begin
              timeout_d   = 1'b1;
              state_d     = S_STOP;
              core_rstn_d = 1'b0;
            end else if (abort_now) begin
              aborted_d   = 1'b1;
              state_d     = S_STOP;
              core_rstn_d = 1'b0;
            end
          end
          default: ;
        endcase
      end

      S_STOP: begin
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= S_IDLE;
      core_rstn_q  <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= 8'd0;
      rd_pend_q    <= 1'b0;
      wr_q         <= 1'b0;
      start_pend_q <= 1'b0;
      halt_q       <= 1'b0;
      timeout_q    <= 1'b0;
      aborted_q    <= 1'b0;
      count_q      <= '0;
      budget_q     <= '0;
      phase_q      <= 4'd0;
      base_q       <= 8'd0;
      target_q     <= 8'd0;
      taken_q      <= 1'b0;
      abort_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_rstn_q  <= core_rstn_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      rd_pend_q    <= rd_pend_d;
      wr_q         <= wr_d;
      start_pend_q <= start_pend_d;
      halt_q       <= halt_d;
      timeout_q    <= timeout_d;
      aborted_q    <= aborted_d;
      count_q      <= count_d;
      budget_q     <= budget_d;
      phase_q      <= phase_d;
      base_q       <= base_d;
      target_q     <= target_d;
      taken_q      <= taken_d;
      abort_seen_q <= abort_seen_d;
    end
  end

  // STOP keeps the host path selected with no write, so the parked core can never disturb memory.
  assign o_mem_raddr   = core_owns ? i_core_raddr : i_host_addr;
  assign o_mem_waddr   = core_owns ? i_core_waddr : i_host_addr;
  assign o_mem_wdata   = core_owns ? i_core_wdata : i_host_wdata;
  assign o_mem_we      = core_owns ? i_core_we    : wr_q;

  assign o_host_ack    = host_ack_q;
  assign o_host_rdata  = host_rdata_q;
  assign o_core_rstn   = core_rstn_q;
  assign o_busy        = (state_q == S_RUN) || (state_q == S_STOP);
  assign o_done        = (state_q == S_DONE);
  assign o_halt        = halt_q;
  assign o_timeout     = timeout_q;
  assign o_aborted     = aborted_q;
  assign o_instr_count = count_q;

endmodule

// File: tb/tb_subleq_run_ctrl.sv
// tb/tb_subleq_run_ctrl.sv - scoreboard bench for subleq_run_ctrl with a behavioural subleq core and memory
module tb_subleq_run_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start, abort;
  logic [CNT_W-1:0] max_instr;
  logic             host_req, host_we;
  logic [7:0]       host_addr, host_wdata;
  logic             host_ack;
  logic [7:0]       host_rdata;
  logic             core_rstn;
  logic [7:0]       core_raddr, core_waddr, core_wdata;
  logic             core_we;
  logic [7:0]       mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic             mem_we;
  logic             busy, done, halt, timeout, aborted;
  logic [CNT_W-1:0] instr_count;

  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;
  logic [31:0] rd_exp_q[$];
  logic [31:0] run_exp_q[$];

  always #5 clk = ~clk;

  subleq_run_ctrl #(.CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_abort(abort), .i_max_instr(max_instr),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_ack(host_ack), .o_host_rdata(host_rdata), .o_core_rstn(core_rstn),
    .i_core_raddr(core_raddr), .i_core_waddr(core_waddr), .i_core_wdata(core_wdata), .i_core_we(core_we),
    .o_mem_raddr(mem_raddr), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata), .o_busy(busy), .o_done(done), .o_halt(halt), .o_timeout(timeout),
    .o_aborted(aborted), .o_instr_count(instr_count)
  );

  logic [7:0] mem [0:255];
  assign mem_rdata = mem[mem_raddr];
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;

  // Behavioural core: 12-phase instruction, write in phase 8, branch target fetched in phase 10.
  logic [3:0] cph;
  logic [7:0] pc, aa, ba, va, vb, cc;
  logic       tk;
  logic [7:0] diff;
  assign diff = vb - va;

  always_comb begin
    core_raddr = pc;
    case (cph)
      4'd0:  core_raddr = pc;
      4'd1:  core_raddr = pc + 8'd1;
      4'd2:  core_raddr = aa;
      4'd3:  core_raddr = ba;
      4'd10: core_raddr = pc + 8'd2;
      default: core_raddr = pc;
    endcase
    core_we    = core_rstn && (cph == 4'd8);
    core_waddr = ba;
    core_wdata = diff;
  end

  always @(posedge clk) begin
    if (!core_rstn) begin
      cph <= 4'd0; pc <= 8'd0; aa <= 8'd0; ba <= 8'd0;
      va <= 8'd0; vb <= 8'd0; cc <= 8'd0; tk <= 1'b0;
    end else begin
      cph <= (cph == 4'd11) ? 4'd0 : cph + 4'd1;
      case (cph)
        4'd0:  aa <= mem_rdata;
        4'd1:  ba <= mem_rdata;
        4'd2:  va <= mem_rdata;
        4'd3:  vb <= mem_rdata;
        4'd8:  tk <= ~diff[7];
        4'd10: cc <= mem_rdata;
        4'd11: pc <= tk ? cc : pc + 8'd3;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic h, input logic t, input logic a, input logic [15:0] cnt);
    return {13'd0, h, t, a, cnt};
  endfunction

  task automatic host_op(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input int exp_lat, input logic [7:0] exp_rd, input logic chk_done);
    int  lat;
    bit  seen;
    if (!we) rd_exp_q.push_back({24'd0, exp_rd});
    @(negedge clk);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    lat = 0; seen = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (host_ack) seen = 1;
    end
    if (!seen) begin
      check("host_ack_timeout", 32'd0, 32'd1);
      if (!we) void'(rd_exp_q.pop_front());
    end else begin
      if (exp_lat >= 0) check("host_ack_lat", lat, exp_lat);
      if (chk_done) check("ack_in_done", {31'd0, done}, 32'd1);
      if (we) check("host_wr_mem_we", {31'd0, mem_we}, 32'd1);
      else    check("host_rdata", {24'd0, host_rdata}, rd_exp_q.pop_front());
    end
    host_req = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", {30'd0, host_ack, mem_we}, 32'd0);
  endtask

  task automatic run_start(input logic [CNT_W-1:0] budget, input logic [31:0] exp_res);
    run_exp_q.push_back(exp_res);
    @(negedge clk);
    start = 1'b1; max_instr = budget;
    @(negedge clk);
    start = 1'b0;
    check("start_core_rstn", {30'd0, core_rstn, busy}, 32'd3);
  endtask

  task automatic wait_done(input int exp_lat);
    int lat = 0;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(run_exp_q.pop_front());
    end else begin
      if (exp_lat >= 0) check("done_lat", lat, exp_lat);
      check("done_core_parked", {30'd0, core_rstn, busy}, 32'd0);
      check("run_result", pack(halt, timeout, aborted, instr_count), run_exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && busy) begin
      check("run_no_ack", {31'd0, host_ack}, 32'd0);
      if (core_rstn) check("run_mem_we", {31'd0, mem_we}, {31'd0, core_we});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; max_instr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'd0; host_wdata = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_core_rstn", {31'd0, core_rstn}, 32'd0);
    check("rst_ack_rdata", {23'd0, host_ack, host_rdata}, 32'd0);
    check("rst_flags_count", pack(halt, timeout, aborted, instr_count), 32'd0);
    check("rst_state", {29'd0, busy, done, mem_we}, 32'd0);
    rstn = 1'b1;

    // host write / read-back
    host_op(1'b1, 8'h10, 8'h5A, 1, 8'h00, 1'b0);
    host_op(1'b0, 8'h10, 8'h00, 2, 8'h5A, 1'b0);

    // self-loop halt; phase-0 cycle is the 1st, o_done in the 14th
    host_op(1'b1, 8'h00, 8'h20, 1, 8'h00, 1'b0);
    host_op(1'b1, 8'h01, 8'h20, 1, 8'h00, 1'b0);
    host_op(1'b1, 8'h02, 8'h00, 1, 8'h00, 1'b0);
    host_op(1'b1, 8'h20, 8'h07, 1, 8'h00, 1'b0);
    run_start(16'd0, pack(1'b1, 1'b0, 1'b0, 16'd1));
    wait_done(13);
    host_op(1'b0, 8'h20, 8'h00, 2, 8'h00, 1'b0);

    // 0 -> 3 -> 0 loop, budget 3
    host_op(1'b1, 8'h02, 8'h03, 1, 8'h00, 1'b0);
    host_op(1'b1, 8'h20, 8'h07, 1, 8'h00, 1'b0);
    host_op(1'b1, 8'h03, 8'h21, 1, 8'h00, 1'b0);
    host_op(1'b1, 8'h04, 8'h21, 1, 8'h00, 1'b0);
    host_op(1'b1, 8'h05, 8'h00, 1, 8'h00, 1'b0);
    host_op(1'b1, 8'h21, 8'h09, 1, 8'h00, 1'b0);
    run_start(16'd3, pack(1'b0, 1'b1, 1'b0, 16'd3));
    wait_done(37);

    // abort pulsed in phase 2 of instruction 1
    run_start(16'd0, pack(1'b0, 1'b0, 1'b1, 16'd1));
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(10);

    // host read held through a budget-2 run
    mon_en = 1'b1;
    run_start(16'd2, pack(1'b0, 1'b1, 1'b0, 16'd2));
    fork
      begin
        wait_done(25);
        mon_en = 1'b0;
      end
      begin
        @(negedge clk);
        host_op(1'b0, 8'h10, 8'h00, -1, 8'h5A, 1'b1);
      end
    join

    // reset in phase 5 of instruction 2
    @(negedge clk);
    start = 1'b1; max_instr = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_rst_count", {16'd0, instr_count}, 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("midrst_state", {28'd0, busy, done, core_rstn, mem_we}, 32'd0);
    check("midrst_flags_count", pack(halt, timeout, aborted, instr_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
